// File: rtl/zld_xc.sv
// zld_xc: zero run-length decoder.
// Expands the (DW+1)-bit token stream from the ZLE encoder into a DW-bit
// value stream. A token with MSB=0 is a literal; MSB=1 is a run of
// (low bits + 1) zeros. Output is fully registered with one cycle latency.
// Optional build macro ZLD_XC_ERR_EN adds a sticky `err` output that flags
// reception of an all-zero literal token.
module zld_xc #(
    parameter int DW = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [DW:0]   i_d,
    input  logic          i_v,
    output logic          i_b,
    output logic [DW-1:0] o_d,
    output logic          o_v,
    input  logic          o_b
`ifdef ZLD_XC_ERR_EN
    ,
    output logic          err
`endif
);

    typedef enum logic {
        S_PASS = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [DW-1:0]   rcnt;
    logic [DW-1:0]   rcnt_nxt;
    logic [DW-1:0]   o_d_nxt;
    logic            o_v_nxt;
    logic            slot_free;
    logic            accept;
    logic            is_run;
    logic [DW-1:0]   tok_val;

    assign is_run  = i_d[DW];
    assign tok_val = i_d[DW-1:0];

    // Output register can take a new value when empty or being drained.
    assign slot_free = !o_v | !o_b;

    // Upstream is held off during reset, while a run is being expanded, and on a downstream stall.
    assign i_b    = reset | (state == S_RUN) | (o_v & o_b);
    assign accept = i_v & !i_b;

    // State register: FSM state, run counter and the registered output stage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_PASS;
            rcnt  <= '0;
            o_d   <= '0;
            o_v   <= 1'b0;
        end else begin
            state <= state_nxt;
            rcnt  <= rcnt_nxt;
            o_d   <= o_d_nxt;
            o_v   <= o_v_nxt;
        end
    end

    // Next-state logic: enter S_RUN for runs longer than one zero, count down while emitting.
    always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        case (state)
            S_PASS: begin
                // The first zero of a run is emitted on accept, so only n>0 needs S_RUN.
                if (accept && is_run && (tok_val != '0)) begin
                    rcnt_nxt  = tok_val;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (slot_free) begin
                    rcnt_nxt = rcnt - DW'(1);
                    if (rcnt == DW'(1)) begin
                        state_nxt = S_PASS;
                    end
                end
            end
            default: begin
                state_nxt = S_PASS;
            end
        endcase
    end

    // Output logic: next value for the output register; holds on stall.
    always_comb begin
        o_d_nxt = o_d;
        o_v_nxt = o_v;
        case (state)
            S_PASS: begin
                if (accept) begin
                    o_d_nxt = is_run ? '0 : tok_val;
                    o_v_nxt = 1'b1;
                end else if (o_v && !o_b) begin
                    o_v_nxt = 1'b0;
                end
            end
            S_RUN: begin
                if (slot_free) begin
                    o_d_nxt = '0;
                    o_v_nxt = 1'b1;
                end
            end
            default: begin
                o_v_nxt = 1'b0;
            end
        endcase
    end

`ifdef ZLD_XC_ERR_EN
    // Sticky flag: an all-zero literal is legal but unexpected from the encoder.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (accept && (i_d == '0)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_zld_xc.sv
// Self-checking bench for zld_xc: directed scenarios plus a randomized
// token stream checked against a queue-based model of the decoded values.
module tb_zld_xc;

    localparam int DW = 3;

    logic          clock;
    logic          reset;
    logic [DW:0]   i_d;
    logic          i_v;
    logic          i_b;
    logic [DW-1:0] o_d;
    logic          o_v;
    logic          o_b;
`ifdef ZLD_XC_ERR_EN
    logic          err;
`endif

    int vectors = 0;
    int miscompares = 0;

    zld_xc #(.DW(DW)) dut (
        .clock (clock),
        .reset (reset),
        .i_d   (i_d),
        .i_v   (i_v),
        .i_b   (i_b),
        .o_d   (o_d),
        .o_v   (o_v),
        .o_b   (o_b)
`ifdef ZLD_XC_ERR_EN
        ,
        .err   (err)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: every accepted token appends its decoded values to a
    // queue; every output transfer must pop the head of that queue.
    logic [DW-1:0] exp_q[$];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_d = '0;

    always @(negedge clock) begin
        logic [DW-1:0] e;
        if (reset) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                vectors++;
                if (o_v !== 1'b1 || o_d !== prev_d) begin
                    miscompares++;
                    $display("FAIL stall_hold: o_v=%b o_d=%0d, required o_v=1 o_d=%0d", o_v, o_d, prev_d);
                end
            end
            if (i_v && !i_b) begin
                if (i_d[DW]) begin
                    for (int k = 0; k < int'(i_d[DW-1:0]) + 1; k++) exp_q.push_back('0);
                end else begin
                    exp_q.push_back(i_d[DW-1:0]);
                end
            end
            if (o_v && !o_b) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL model_unexpected_out: o_d=%0d, required no output", o_d);
                end else begin
                    e = exp_q.pop_front();
                    if (o_d !== e) begin
                        miscompares++;
                        $display("FAIL model_value: o_d=%0d, required %0d", o_d, e);
                    end
                end
            end
            prev_stall = o_v && o_b;
            prev_d = o_d;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a token and hold it until accepted; returns just after the accepting edge.
    task automatic send(input logic [DW:0] t);
        int w;
        i_d = t;
        i_v = 1'b1;
        w = 0;
        @(negedge clock);
        while (i_b && w < 100) begin
            tick();
            @(negedge clock);
            w++;
        end
        if (i_b) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: token %h not accepted, i_b=%b required 0", t, i_b);
        end
        tick();
        i_v = 1'b0;
        i_d = 4'($urandom_range(0, 15));
    endtask

    task automatic test_reset();
        reset = 1'b1;
        i_v = 1'b0;
        i_d = '0;
        o_b = 1'b0;
        @(posedge clock);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            vectors++;
            if (i_b !== 1'b1 || o_v !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold: i_b=%b o_v=%b, required i_b=1 o_v=0", i_b, o_v);
            end
            @(posedge clock);
        end
        #1 reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            vectors++;
            if (i_b !== 1'b0 || o_v !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_idle: i_b=%b o_v=%b, required i_b=0 o_v=0", i_b, o_v);
            end
            tick();
        end
    endtask

    task automatic test_literals();
        logic [DW-1:0] exp_d[3] = '{3'd5, 3'd3, 3'd7};
        logic [DW:0]   tok[3]   = '{4'h5, 4'h3, 4'h7};
        o_b = 1'b0;
        i_v = 1'b1;
        i_d = tok[0];
        @(negedge clock);
        vectors++;
        if (i_b !== 1'b0) begin
            miscompares++;
            $display("FAIL lit_first_accept: i_b=%b, required 0", i_b);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k < 2) i_d = tok[k+1];
            else i_v = 1'b0;
            @(negedge clock);
            vectors++;
            if (o_v !== 1'b1 || o_d !== exp_d[k]) begin
                miscompares++;
                $display("FAIL lit_out%0d: o_v=%b o_d=%0d, required o_v=1 o_d=%0d", k, o_v, o_d, exp_d[k]);
            end
            if (k < 2) begin
                vectors++;
                if (i_b !== 1'b0) begin
                    miscompares++;
                    $display("FAIL lit_ready%0d: i_b=%b, required 0", k, i_b);
                end
            end
        end
        tick();
        @(negedge clock);
        vectors++;
        if (o_v !== 1'b0) begin
            miscompares++;
            $display("FAIL lit_drain: o_v=%b, required 0", o_v);
        end
        tick();
    endtask

    task automatic test_short_run();
        logic [DW-1:0] exp_d[5] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd2};
        int busy = 0;
        o_b = 1'b0;
        i_v = 1'b1;
        i_d = 4'hB;
        @(negedge clock);
        vectors++;
        if (i_b !== 1'b0) begin
            miscompares++;
            $display("FAIL run_accept: i_b=%b, required 0", i_b);
        end
        tick();
        i_d = 4'h2;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            vectors++;
            if (o_v !== 1'b1 || o_d !== exp_d[k]) begin
                miscompares++;
                $display("FAIL run_out%0d: o_v=%b o_d=%0d, required o_v=1 o_d=%0d", k, o_v, o_d, exp_d[k]);
            end
            if (i_v && i_b) busy++;
            tick();
            if (k >= 3) i_v = 1'b0;
        end
        vectors++;
        if (busy != 3) begin
            miscompares++;
            $display("FAIL run_busy_cycles: %0d, required 3", busy);
        end
    endtask

    task automatic test_max_run_stall();
        int zeros = 0;
        o_b = 1'b0;
        send(4'hF);
        for (int k = 0; k < 40; k++) begin
            o_b = (k % 2 == 0);
            @(negedge clock);
            if (o_v && !o_b && o_d == '0) zeros++;
            tick();
        end
        vectors++;
        if (zeros != 8) begin
            miscompares++;
            $display("FAIL maxrun_zero_count: %0d, required 8", zeros);
        end
        o_b = 1'b0;
        send(4'h4);
        @(negedge clock);
        vectors++;
        if (o_v !== 1'b1 || o_d !== 3'd4) begin
            miscompares++;
            $display("FAIL maxrun_next_lit: o_v=%b o_d=%0d, required o_v=1 o_d=4", o_v, o_d);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int cnt = 0;
        int outs = 0;
        int bad = 0;
        o_b = 1'b0;
        send(4'hF);
        for (int k = 0; k < 20 && cnt < 3; k++) begin
            @(negedge clock);
            if (o_v && !o_b) cnt++;
            if (cnt < 3) tick();
        end
        @(posedge clock);
        #1 reset = 1'b1;
        #1;
        vectors++;
        if (o_v !== 1'b0 || i_b !== 1'b1) begin
            miscompares++;
            $display("FAIL midrun_reset: o_v=%b i_b=%b, required o_v=0 i_b=1", o_v, i_b);
        end
        tick();
        tick();
        reset = 1'b0;
        send(4'h1);
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (o_v && !o_b) begin
                outs++;
                if (o_d !== 3'd1) bad++;
            end
            tick();
        end
        vectors++;
        if (outs != 1 || bad != 0) begin
            miscompares++;
            $display("FAIL midrun_after: %0d outputs (%0d not 1), required exactly one value 1", outs, bad);
        end
    endtask

    task automatic test_literal_zero();
        o_b = 1'b0;
`ifdef ZLD_XC_ERR_EN
        @(negedge clock);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_before: err=%b, required 0", err);
        end
        tick();
`endif
        i_v = 1'b1;
        i_d = 4'h0;
        @(negedge clock);
        vectors++;
        if (i_b !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_accept: i_b=%b, required 0", i_b);
        end
        tick();
        i_d = 4'h6;
        @(negedge clock);
        vectors++;
        if (o_v !== 1'b1 || o_d !== 3'd0) begin
            miscompares++;
            $display("FAIL zero_out: o_v=%b o_d=%0d, required o_v=1 o_d=0", o_v, o_d);
        end
`ifdef ZLD_XC_ERR_EN
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_set: err=%b, required 1", err);
        end
`endif
        tick();
        i_v = 1'b0;
        @(negedge clock);
        vectors++;
        if (o_v !== 1'b1 || o_d !== 3'd6) begin
            miscompares++;
            $display("FAIL zero_next: o_v=%b o_d=%0d, required o_v=1 o_d=6", o_v, o_d);
        end
        tick();
    endtask

    task automatic test_random();
        int sent = 0;
        int cyc = 0;
        int w = 0;
        logic acc;
        while (sent < 300 && cyc < 6000) begin
            o_b = ($urandom_range(0, 3) == 0);
            if (!i_v) begin
                if ($urandom_range(0, 2) != 0) begin
                    i_v = 1'b1;
                    i_d = 4'($urandom_range(0, 15));
                end else begin
                    i_d = 4'($urandom_range(0, 15));
                end
            end
            @(negedge clock);
            acc = i_v && !i_b;
            tick();
            if (acc) begin
                i_v = 1'b0;
                sent++;
            end
            cyc++;
        end
        vectors++;
        if (sent < 300) begin
            miscompares++;
            $display("FAIL random_timeout: %0d tokens accepted, required 300", sent);
        end
        o_b = 1'b0;
        i_v = 1'b0;
        while ((exp_q.size() != 0 || o_v) && w < 100) begin
            tick();
            w++;
        end
        @(negedge clock);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL random_drain: %0d values never produced, required 0", exp_q.size());
        end
`ifdef ZLD_XC_ERR_EN
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky: err=%b, required 1", err);
        end
`endif
        tick();
    endtask

    task automatic test_final_reset();
        reset = 1'b1;
        #1;
        vectors++;
        if (o_v !== 1'b0 || i_b !== 1'b1) begin
            miscompares++;
            $display("FAIL final_reset: o_v=%b i_b=%b, required o_v=0 i_b=1", o_v, i_b);
        end
`ifdef ZLD_XC_ERR_EN
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear: err=%b, required 0", err);
        end
`endif
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        i_v = 1'b0;
        i_d = '0;
        o_b = 1'b0;
        test_reset();
        test_literals();
        test_short_run();
        test_max_run_stall();
        test_reset_mid_run();
        test_literal_zero();
        test_random();
        test_final_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/zld_xc.md
Name: zld_xc

Overview:
- Zero run-length decoder: the stage directly downstream of the ZLE encoder.
- Consumes the 4-bit token stream and regenerates the 3-bit value stream, expanding run tokens into consecutive zeros.
- Streams use the team's data/valid/back-pressure convention:
  - a transfer occurs on a rising clock edge when *_v=1 and *_b=0;
  - the *_b output from a stage means "not ready".

Parameters:
- DW, 3, output value width. Token width is DW+1. The run field is DW bits, so the maximum run is 2^DW zeros.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_d  input  DW+1  token: MSB=0 is a literal value i_d[DW-1:0]; MSB=1 is a run of (i_d[DW-1:0]+1) zeros.
- i_v  input  1  token valid.
- i_b  output  1  back-pressure to upstream; 1 means the token is not accepted this cycle.
- o_d  output  DW  decoded value.
- o_v  output  1  output valid.
- o_b  input  1  back-pressure from downstream.

Behaviour:
- Reset (asynchronous, active-high): state=S_PASS, rcnt=0, o_v=0, o_d=0. i_b=1 while reset is high.
- Output register: o_d/o_v come from flops, never combinational from i_d. Latency is token accept -> o_v is 1 cycle. Peak rate is 1 value/cycle.
- i_b = reset | (state==S_RUN) | (o_v & o_b). This is combinational from registered state and o_b.
- Stall hold: while o_v=1 and o_b=1, o_d and o_v stay stable.
- Slot free: slot_free = !o_v | !o_b.
- S_PASS, token accepted (i_v & !i_b):
  - Literal token: o_d<=i_d[DW-1:0], o_v<=1.
  - Literal zero (token all-zero): emitted as a single 0. This is legal and equals a run of 1.
  - Run token with n=i_d[DW-1:0]: o_d<=0, o_v<=1.
    - If n>0: rcnt<=n, state<=S_RUN.
    - If n=0: stay in S_PASS.
- S_PASS, no accept: if o_v & !o_b, then o_v<=0.
- S_RUN: no token is accepted.
  - If slot_free: o_d<=0, o_v<=1, rcnt<=rcnt-1.
  - When rcnt==1 at that update: state<=S_PASS.
  - If not slot_free: hold everything.
- Run length and bubbles:
  - Run token n yields exactly n+1 zeros on o_d, with no extra bubbles when o_b=0.
  - The next token is accepted on the cycle after the last zero is loaded.
  - A token is therefore accepted in the same cycle that the final zero appears on o_v.
- Max run: rcnt is DW bits. The max run (n=2^DW-1) loads rcnt=2^DW-1 without overflow.
- Reset mid-run: the remaining zeros are discarded and no partial output is held. The first token after release decodes normally.
- Ignored i_d: i_d is ignored when i_v=0 or i_b=1. Upstream must hold the token until it is accepted.

Optional Feature:
- Macro ZLD_XC_ERR_EN.
- Defined:
  - Adds port err (output, 1 bit), a sticky flag.
  - err is set on the cycle after accepting an all-zero literal token. That token is still decoded as a single 0.
  - err is cleared only by reset; reset value 0.
- Undefined: no err port and no flag logic. Decode behaviour is identical.

Test Plan:
- Reset/idle: hold reset 3 cycles, then release -> i_b=1 during reset and 0 after; o_v=0 until the first token.
- Literals: tokens 0x5, 0x3, 0x7 back-to-back with o_b=0 -> o_d=5,3,7 on consecutive cycles, each 1 cycle after accept; i_b stays 0.
- Short run then literal: tokens 0xB, 0x2 with o_b=0 -> o_d=0,0,0,0,2 on 5 consecutive cycles; i_b=1 for exactly 3 cycles.
- Max run under stall: token 0xF with o_b toggling 1/0 each cycle -> exactly 8 zeros transferred; o_d/o_v stable on every o_b=1 cycle; then token 0x4 -> o_d=4.
- Reset mid-run: token 0xF, assert reset after 3 zeros transferred -> o_v=0 immediately; after release, token 0x1 -> only o_d=1 appears, with no leftover zeros.
- Literal zero: token 0x0, then 0x6 -> o_d=0,6; with ZLD_XC_ERR_EN, err=1 from the cycle after the 0x0 accept until the next reset; without the macro, the build has no err port.
